// File: rtl/arm_pkg.sv
// Shared types and helpers for the ARM unified memory.
package arm_pkg;

  typedef logic [31:0] word_t;

  localparam int WORD_BYTES = 4;

  // A word access is aligned when the two byte-offset bits are clear.
  function automatic logic is_aligned(input logic [1:0] byte_off);
    return byte_off == 2'b00;
  endfunction

endpackage

// File: rtl/arm_memory_if.sv
// Bus bundle for the dual-port ARM memory.
// Handshake: no valid/ready; every port presents an access each cycle, and
// data_out/excpt answer the access presented at the previous rising edge.
interface arm_memory_if
  import arm_pkg::*;
#(
  parameter int AW = 32
);

  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  word_t         data_in0;
  word_t         data_in1;
  logic [0:1]    we;
  logic [0:1]    excpt;
  word_t         data_out0;
  word_t         data_out1;

  modport master (
    output addr0, addr1, data_in0, data_in1, we,
    input  excpt, data_out0, data_out1
  );

  modport slave (
    input  addr0, addr1, data_in0, data_in1, we,
    output excpt, data_out0, data_out1
  );

endinterface

// File: rtl/arm_mem_port_chk.sv
// Combinational legality check for one memory port: word index and illegal flag.
module arm_mem_port_chk
  import arm_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
) (
  input  logic [AW-1:0] addr,
  output logic [AW-3:0] idx,
  output logic          illegal
);

  assign idx = addr[AW-1:2];

  // No aliasing: any index at or beyond DEPTH is rejected outright.
  assign illegal = !is_aligned(addr[1:0]) || ({2'b00, idx} >= AW'(DEPTH));

endmodule

// File: rtl/arm_memory.sv
// Dual-port, word-wide, byte-addressed unified memory with write-first reads
// and per-port registered exception flags.
module arm_memory
  import arm_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
) (
  input logic        clk,
  input logic        rst,
  arm_memory_if.slave bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  word_t mem [DEPTH];

  logic [AW-3:0] idx0, idx1;
  logic          ill0, ill1;
  logic [IW-1:0] m0, m1;
  logic          w0, w1;
  logic          same_word;
  word_t         rd0, rd1;

  arm_mem_port_chk #(.DEPTH(DEPTH), .AW(AW)) u_chk0 (
    .addr    (bus.addr0),
    .idx     (idx0),
    .illegal (ill0)
  );

  arm_mem_port_chk #(.DEPTH(DEPTH), .AW(AW)) u_chk1 (
    .addr    (bus.addr1),
    .idx     (idx1),
    .illegal (ill1)
  );

  assign m0        = idx0[IW-1:0];
  assign m1        = idx1[IW-1:0];
  assign w0        = bus.we[0] && !ill0;
  assign w1        = bus.we[1] && !ill1;
  assign same_word = (idx0 == idx1);

  // Port 1's write is issued last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w0) mem[m0] <= bus.data_in0;
      if (w1) mem[m1] <= bus.data_in1;
    end
  end

  // Write-first bypass; port 1's data has priority whenever it targets the word.
  always_comb begin
    rd0 = mem[m0];
    if (w0)              rd0 = bus.data_in0;
    if (w1 && same_word) rd0 = bus.data_in1;
    if (ill0)            rd0 = '0;
  end

  always_comb begin
    rd1 = mem[m1];
    if (w0 && same_word) rd1 = bus.data_in0;
    if (w1)              rd1 = bus.data_in1;
    if (ill1)            rd1 = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out0 <= '0;
      bus.data_out1 <= '0;
      bus.excpt     <= 2'b00;
    end else begin
      bus.data_out0 <= rd0;
      bus.data_out1 <= rd1;
      bus.excpt[0]  <= ill0;
      bus.excpt[1]  <= ill1;
    end
  end

endmodule

// File: tb/tb_arm_memory.sv
// Self-checking bench for arm_memory: directed test-plan sequences plus
// randomized traffic compared against a word-array model every cycle.
module tb_arm_memory;
  import arm_pkg::*;

  localparam int DEPTH = 1024;
  localparam int EW    = 68;  // {known0, known1, ex0, ex1, out0, out1}

  logic clk;
  logic rst;

  arm_memory_if #(.AW(32)) bus ();

  arm_memory #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  word_t mdl   [DEPTH];
  bit    known [DEPTH];
  logic [EW-1:0] exp_q[$];

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DEPTH);
  endfunction

  always @(posedge clk) begin
    logic [31:0] a0, a1;
    bit l0, l1, k0, k1;
    word_t o0, o1;
    a0 = bus.addr0;
    a1 = bus.addr1;
    l0 = legal(a0);
    l1 = legal(a1);
    if (rst) begin
      exp_q.push_back({2'b11, 2'b00, 32'h0, 32'h0});
    end else begin
      // Apply writes (port 1 last so it wins), then read the updated array.
      if (bus.we[0] && l0) begin mdl[a0/4] = bus.data_in0; known[a0/4] = 1'b1; end
      if (bus.we[1] && l1) begin mdl[a1/4] = bus.data_in1; known[a1/4] = 1'b1; end
      k0 = l0 ? known[a0/4] : 1'b1;
      k1 = l1 ? known[a1/4] : 1'b1;
      o0 = (l0 && k0) ? mdl[a0/4] : 32'h0;
      o1 = (l1 && k1) ? mdl[a1/4] : 32'h0;
      exp_q.push_back({k0, k1, !l0, !l1, o0, o1});
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("excpt0", {31'h0, bus.excpt[0]}, {31'h0, e[65]});
      chk("excpt1", {31'h0, bus.excpt[1]}, {31'h0, e[64]});
      if (e[67]) chk("data_out0", bus.data_out0, e[63:32]);
      if (e[66]) chk("data_out1", bus.data_out1, e[31:0]);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic we0, input logic we1,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input word_t d0, input word_t d1);
    rst          = r;
    bus.we[0]    = we0;
    bus.we[1]    = we1;
    bus.addr0    = a0;
    bus.addr1    = a1;
    bus.data_in0 = d0;
    bus.data_in1 = d1;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6) return 32'($urandom_range(0, 31)) * 4;
    if (r == 7) return 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
    if (r == 8) return 32'h1000 + 32'($urandom_range(0, 1000)) * 4;
    return ($urandom_range(0, 1) == 0) ? 32'h0000_0FFC : 32'hFFFF_FFFC;
  endfunction

  word_t prog [4] = '{32'hE3A00001, 32'hE3A01002, 32'hE0802001, 32'hEAFFFFFE};

  initial begin
    rst = 1'b1;
    bus.we = 2'b00;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.data_in0 = '0;
    bus.data_in1 = '0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reset_out0", bus.data_out0, 32'h0);
    chk("reset_excpt", {30'h0, bus.excpt}, 32'h0);

    // Sequential load with port 1 watching the same word.
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 32'(4 * k), 32'(4 * k), prog[k], 32'h0);
      chk("load_wf_out1", bus.data_out1, prog[k]);
      chk("load_excpt", {30'h0, bus.excpt}, 32'h0);
    end

    // Readback.
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 32'(4 * k), 32'h0, 32'h0, 32'h0);
      chk("readback_out0", bus.data_out0, prog[k]);
    end

    // Misaligned write on port 1 is suppressed.
    cyc(0, 0, 1, 32'h0, 32'h6, 32'h0, 32'hDEADBEEF);
    chk("misalign_excpt1", {31'h0, bus.excpt[1]}, 32'h1);
    chk("misalign_out1", bus.data_out1, 32'h0);
    cyc(0, 0, 0, 32'h4, 32'h4, 32'h0, 32'h0);
    chk("misalign_keep", bus.data_out0, 32'hE3A01002);

    // Out of range and the last legal word.
    cyc(0, 1, 0, 32'h1000, 32'h0, 32'h55555555, 32'h0);
    chk("oor_excpt0", {31'h0, bus.excpt[0]}, 32'h1);
    chk("oor_out0", bus.data_out0, 32'h0);
    cyc(0, 1, 0, 32'hFFC, 32'hFFC, 32'hCAFEF00D, 32'h0);
    chk("top_excpt", {30'h0, bus.excpt}, 32'h0);
    chk("top_out1", bus.data_out1, 32'hCAFEF00D);

    // Same-word collision: port 1 wins.
    cyc(0, 1, 1, 32'h10, 32'h10, 32'h11111111, 32'h22222222);
    chk("coll_out0", bus.data_out0, 32'h22222222);
    chk("coll_out1", bus.data_out1, 32'h22222222);
    cyc(0, 0, 0, 32'h10, 32'h10, 32'h0, 32'h0);
    chk("coll_read", bus.data_out0, 32'h22222222);

    // Reset blocks the write and clears outputs, not memory.
    cyc(1, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rst_out0", bus.data_out0, 32'h0);
    chk("rst_out1", bus.data_out1, 32'h0);
    cyc(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rst_keep", bus.data_out0, 32'hE3A00001);

    // Initialise the random working set, then randomized traffic.
    for (int k = 0; k < 32; k++)
      cyc(0, 1, 0, 32'(4 * k), 32'(4 * ((k + 7) % 32)), $urandom, 32'h0);
    for (int n = 0; n < 600; n++)
      cyc(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          rand_addr(), rand_addr(), $urandom, $urandom);

    cyc(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
